cic_decim: RTL and testbench

- Third-order CIC decimation filter for the 1-bit delta-sigma modulator bitstream.
- Sits directly downstream of the decimation-strobe generator and consumes one of its one-cycle strobes (en_8/en_16/en_32/en_64) as its decimation instant.
- Produces signed, full-precision decimated samples with a one-cycle valid pulse; these feed the later compensation/FIR stages.

---
 rtl/cic_decim_pkg.sv | 24 ++
 rtl/cic_integ.sv | 22 ++
 rtl/cic_decim.sv | 57 +++++
 tb/tb_cic_decim.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cic_decim_pkg.sv
// rtl/cic_decim_pkg.sv - shared constants and helpers for the delta-sigma CIC decimator
package cic_decim_pkg;

  // Number of integrator/comb stage pairs.
  localparam int CIC_ORDER = 3;

  // Supported range of log2(R), matching the en_8..en_64 strobes.
  localparam int DECIM_LOG2_MIN = 3;
  localparam int DECIM_LOG2_MAX = 6;

  // Full-precision datapath width: R^ORDER gain plus sign and one bit of headroom.
  function automatic int cic_out_w(input int decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

  // Magnitude of the output for an all-ones or all-zeros bitstream.
  function automatic int cic_full_scale(input int decim_log2);
    return 1 << (CIC_ORDER * decim_log2);
  endfunction

  localparam int FULL_SCALE_D6 = 262144;
  localparam int FULL_SCALE_D3 = 512;

endpackage

// File: rtl/cic_integ.sv
// rtl/cic_integ.sv - single wrapping accumulator stage of the CIC integrator chain
module cic_integ
  import cic_decim_pkg::*;
#(
  parameter int W = cic_out_w(6)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] acc
);

  // Accumulate every cycle; overflow wraps modulo 2^W, which the combs undo.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= acc + din;
    end
  end

endmodule

// File: rtl/cic_decim.sv
// rtl/cic_decim.sv - third-order CIC decimator for the 1-bit modulator bitstream
module cic_decim
  import cic_decim_pkg::*;
#(
  parameter  int DECIM_LOG2 = 6,
  localparam int OUT_W      = cic_out_w(DECIM_LOG2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    en,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);

  logic signed [OUT_W-1:0] x;
  logic signed [OUT_W-1:0] i1, i2, i3;
  logic signed [OUT_W-1:0] s, c1, c2, c3;
  logic signed [OUT_W-1:0] d1, d2, d3;

  // Map the bitstream to +1 / -1 at full datapath width.
  always_comb begin
    x = din ? {{(OUT_W-1){1'b0}}, 1'b1} : {OUT_W{1'b1}};
  end

  cic_integ #(.W(OUT_W)) u_integ1 (.clk(clk), .rst(rst), .din(x),  .acc(i1));
  cic_integ #(.W(OUT_W)) u_integ2 (.clk(clk), .rst(rst), .din(i1), .acc(i2));
  cic_integ #(.W(OUT_W)) u_integ3 (.clk(clk), .rst(rst), .din(i2), .acc(i3));

  // Comb differences on the current decimated sample, using last strobe's history.
  always_comb begin
    s  = i3;
    c1 = s  - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // On each strobe, advance the comb delays and register the new output sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= en;
      if (en) begin
        d1   <= s;
        d2   <= c1;
        d3   <= c2;
        dout <= c3;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// tb/tb_cic_decim.sv - directed self-checking bench for cic_decim at R=64 and R=8
module tb_cic_decim;
  import cic_decim_pkg::*;

  localparam int W6 = cic_out_w(6);
  localparam int W3 = cic_out_w(3);

  logic clk;
  logic rst6, din6, en6, valid6;
  logic signed [W6-1:0] dout6;
  logic rst3, din3, en3, valid3;
  logic signed [W3-1:0] dout3;

  int vec  = 0;
  int miss = 0;

  // Hand-computed first outputs after reset for din=1, en every 64th cycle.
  int trans6 [4] = '{39711, 214242, 262143, 262144};

  cic_decim #(.DECIM_LOG2(6)) u_dut6 (
    .clk(clk), .rst(rst6), .din(din6), .en(en6), .dout(dout6), .dout_valid(valid6)
  );

  cic_decim #(.DECIM_LOG2(3)) u_dut3 (
    .clk(clk), .rst(rst3), .din(din3), .en(en3), .dout(dout3), .dout_valid(valid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat_bit(input int pat, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (k % 2) == 0;
      default: return (k % 4) != 3;
    endcase
  endfunction

  task automatic reset6();
    rst6 = 1'b1; en6 = 1'b0; din6 = 1'b0;
    tick();
    tick();
    rst6 = 1'b0;
  endtask

  task automatic reset3();
    rst3 = 1'b1; en3 = 1'b0; din3 = 1'b0;
    tick();
    tick();
    rst3 = 1'b0;
  endtask

  // Drive a pattern at R=64 from the current state and check n_out outputs.
  task automatic run6(input int pat, input int n_out, input int exp_v,
                      input bit chk_transient, input string tag);
    int  k      = 0;
    int  got    = 0;
    int  budget = n_out * 64 + 16;
    logic en_exp;
    while (got < n_out && k < budget) begin
      din6   = pat_bit(pat, k);
      en6    = (k % 64) == 63;
      en_exp = en6;
      tick();
      k++;
      check({tag, "_valid"}, valid6, en_exp);
      if (valid6 === 1'b1) begin
        got++;
        if (got >= 4)
          check({tag, "_dout"}, dout6, exp_v);
        else if (chk_transient)
          check({tag, "_transient"}, dout6, trans6[got-1]);
      end
    end
    en6 = 1'b0;
    check({tag, "_count"}, got, n_out);
  endtask

  initial begin
    rst6 = 1'b1; din6 = 1'b0; en6 = 1'b0;
    rst3 = 1'b1; din3 = 1'b0; en3 = 1'b0;
    #1;
    check("reset_dout6", dout6, 0);
    check("reset_valid6", valid6, 0);
    check("reset_dout3", dout3, 0);
    check("reset_valid3", valid3, 0);

    // R=64, constant +1 over many integrator wraps.
    reset6();
    run6(0, 200, 262144, 1'b1, "d6_ones");

    // R=64, constant -1.
    reset6();
    run6(1, 6, -262144, 1'b0, "d6_zeros");

    // R=64, alternating 1,0 has zero mean.
    reset6();
    run6(2, 6, 0, 1'b0, "d6_alt");

    // R=64, 1,1,1,0 has mean one half.
    reset6();
    run6(3, 6, 131072, 1'b0, "d6_3of4");

    // Reset between strobes, including a strobe during reset, then replay.
    reset6();
    run6(0, 10, 262144, 1'b1, "d6_pre_rst");
    din6 = 1'b1;
    repeat (20) tick();
    en6 = 1'b1;
    tick();
    en6 = 1'b0;
    check("d6_strobe_before_rst", valid6, 1);
    rst6 = 1'b1;
    #1;
    check("d6_rst_dout", dout6, 0);
    check("d6_rst_valid", valid6, 0);
    en6 = 1'b1;
    tick();
    check("d6_rst_en_valid", valid6, 0);
    check("d6_rst_en_dout", dout6, 0);
    en6  = 1'b0;
    rst6 = 1'b0;
    run6(0, 6, 262144, 1'b1, "d6_post_rst");

    // R=8, constant +1.
    reset3();
    begin
      int got3 = 0;
      int k3   = 0;
      while (got3 < 6 && k3 < 64) begin
        din3 = 1'b1;
        en3  = (k3 % 8) == 7;
        tick();
        k3++;
        if (valid3 === 1'b1) begin
          got3++;
          if (got3 >= 4) check("d3_ones_dout", dout3, 512);
        end
      end
      en3 = 1'b0;
      check("d3_ones_count", got3, 6);
    end

    // R=8 build with en held high from the first cycle after reset.
    reset3();
    din3 = 1'b1;
    en3  = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      check("d3_cont_valid", valid3, 1);
      check("d3_cont_dout", dout3, (j < 3) ? 0 : 1);
    end
    en3 = 1'b0;
    tick();
    check("d3_cont_release_valid", valid3, 0);
    check("d3_cont_hold_dout", dout3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
